// File: rtl/led_indicator_ctrl_pkg.sv
// Shared types and helpers for the mode/status LED driver.
// State encoding, default timing constants and a one-hot MSB-first decoder.
package led_indicator_ctrl_pkg;

  typedef enum logic {
    STEADY = 1'b0,
    FLASH  = 1'b1
  } state_e;

  localparam int DEF_TICK_DIV      = 25_000_000;
  localparam int DEF_FLASH_TOGGLES = 6;
  localparam int MAX_LED_W         = 256;

  // Mode m lights bit n-1-m, so mode 0 is the leftmost LED on the board.
  function automatic logic [MAX_LED_W-1:0] onehot_msb(input int unsigned m, input int unsigned n);
    onehot_msb = {{(MAX_LED_W-1){1'b0}}, 1'b1} << (n - 1 - m);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider: 1-cycle tick every TICK_DIV clocks, with a
// synchronous clear so a blinker can restart its timebase on demand.
module led_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == TERM);
  assign o_tick = w_term && !i_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            r_cnt <= '0;
    else if (i_clr || w_term) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/led_indicator_ctrl.sv
// Mode/status LED driver: one-hot mode bank that flashes after every mode
// change, plus a status LED. Optional dimming via `define LED_PWM_EN.
module led_indicator_ctrl
  import led_indicator_ctrl_pkg::*;
#(
  parameter int MODE_W        = 2,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int FLASH_TOGGLES = DEF_FLASH_TOGGLES,
  parameter int PWM_W         = 4,
  localparam int unsigned N_LED = 2**MODE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [MODE_W-1:0] sw_mode,
  input  logic              sw,
  input  logic [PWM_W-1:0]  duty,
  output logic [N_LED-1:0]  led_mode,
  output logic              led_stat,
  output logic              flashing
);

  localparam int FCNT_W = $clog2(FLASH_TOGGLES + 1);

  logic [MODE_W-1:0] r_mode_s1, r_mode_s2, r_committed;
  logic              r_sw_s1, r_sw_s2;
  state_e            r_state;
  logic              r_phase;
  logic [FCNT_W-1:0] r_fcnt;
  logic [N_LED-1:0]  r_led_mode;
  logic              r_led_stat, r_flashing;

  logic              w_change, w_tick;
  state_e            w_state_nx;
  logic [MODE_W-1:0] w_commit_nx;
  logic              w_phase_nx;
  logic [FCNT_W-1:0] w_fcnt_nx;
  logic [N_LED-1:0]  w_onehot, w_led_nx;
  logic              w_stat_nx, w_flash_nx, w_pwm_on;

  // Inputs are asynchronous to clk: two-flop synchronisers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_s1 <= '0;
      r_mode_s2 <= '0;
      r_sw_s1   <= 1'b0;
      r_sw_s2   <= 1'b0;
    end else begin
      r_mode_s1 <= sw_mode;
      r_mode_s2 <= r_mode_s1;
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
    end
  end

  assign w_change = (r_mode_s2 != r_committed);

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_change),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= STEADY;
      r_committed <= '0;
      r_phase     <= 1'b0;
      r_fcnt      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_committed <= w_commit_nx;
      r_phase     <= w_phase_nx;
      r_fcnt      <= w_fcnt_nx;
    end
  end

  // A new mode always wins, even mid-flash: the sequence restarts dark.
  always_comb begin
    w_state_nx  = r_state;
    w_commit_nx = r_committed;
    w_phase_nx  = r_phase;
    w_fcnt_nx   = r_fcnt;
    if (w_change) begin
      w_state_nx  = FLASH;
      w_commit_nx = r_mode_s2;
      w_phase_nx  = 1'b0;
      w_fcnt_nx   = FCNT_W'(FLASH_TOGGLES);
    end else if (r_state == FLASH && w_tick) begin
      w_phase_nx = ~r_phase;
      w_fcnt_nx  = r_fcnt - 1'b1;
      if (r_fcnt == FCNT_W'(1)) w_state_nx = STEADY;
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pwm_cnt <= '0;
    else          r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // All-ones duty has to be special-cased, since cnt < duty misses cnt == max.
  assign w_pwm_on = (duty == {PWM_W{1'b1}}) || (r_pwm_cnt < duty);
`else
  logic w_unused_duty;
  assign w_unused_duty = ^duty;
  assign w_pwm_on      = 1'b1;
`endif

  // Outputs are decoded from next-state values so the output flops line up
  // with the state flops and present no combinational path to the pins.
  always_comb begin
    w_onehot   = N_LED'(onehot_msb(32'(w_commit_nx), N_LED));
    w_flash_nx = (w_state_nx == FLASH);
    w_led_nx   = (w_flash_nx && !w_phase_nx) ? '0 : w_onehot;
    w_led_nx   = w_led_nx & {N_LED{w_pwm_on}};
    w_stat_nx  = r_sw_s2 & w_pwm_on;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_mode <= '0;
      r_led_stat <= 1'b0;
      r_flashing <= 1'b0;
    end else begin
      r_led_mode <= w_led_nx;
      r_led_stat <= w_stat_nx;
      r_flashing <= w_flash_nx;
    end
  end

  assign led_mode = r_led_mode;
  assign led_stat = r_led_stat;
  assign flashing = r_flashing;

endmodule

// File: tb/tb_led_indicator_ctrl.sv
// Scoreboard bench for led_indicator_ctrl with TICK_DIV=4, FLASH_TOGGLES=6.
module tb_led_indicator_ctrl;

  localparam int TD = 4;
  localparam int FT = 6;
  localparam int FLASH_LEN = TD * FT;

  typedef struct {
    logic [3:0] led;
    logic       stat;
    logic       fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sw_mode = 2'b00;
  logic       sw = 1'b1;
  logic [3:0] duty = 4'hF;
  logic [3:0] led_mode;
  logic       led_stat;
  logic       flashing;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic cur_stat = 1'b0;

  led_indicator_ctrl #(
    .MODE_W(2), .TICK_DIV(TD), .FLASH_TOGGLES(FT), .PWM_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_mode(sw_mode), .sw(sw), .duty(duty),
    .led_mode(led_mode), .led_stat(led_stat), .flashing(flashing)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_steady(input logic [3:0] led, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.led = led; e.stat = cur_stat; e.fl = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // t = cycles after the detect edge; lit on odd tick intervals, steady from FLASH_LEN.
  task automatic push_flash(input logic [3:0] led, input int t0, input int t1);
    exp_t e;
    for (int t = t0; t <= t1; t++) begin
      e.stat = cur_stat;
      if (t >= FLASH_LEN) begin
        e.led = led; e.fl = 1'b0;
      end else begin
        e.led = ((t / TD) % 2 == 1) ? led : 4'b0000;
        e.fl  = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; sw_mode = 2'b00; sw = 1'b1;
    cur_stat = 1'b0;
    repeat (3) step();
    n_cmp++; if (led_mode !== 4'b0000) begin n_err++; $display("FAIL reset_led_mode: got %b want 0000", led_mode); end
    n_cmp++; if (led_stat !== 1'b0) begin n_err++; $display("FAIL reset_led_stat: got %b want 0", led_stat); end
    n_cmp++; if (flashing !== 1'b0) begin n_err++; $display("FAIL reset_flashing: got %b want 0", flashing); end
    reset_n = 1'b1;
    push_steady(4'b1000, 2);
    cur_stat = 1'b1;
    push_steady(4'b1000, 3);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_cmp++; if (led_mode !== e.led) begin n_err++; $display("FAIL reset_release_led: got %b want %b", led_mode, e.led); end
      n_cmp++; if (led_stat !== e.stat) begin n_err++; $display("FAIL reset_release_stat: got %b want %b", led_stat, e.stat); end
      n_cmp++; if (flashing !== e.fl) begin n_err++; $display("FAIL reset_release_flashing: got %b want %b", flashing, e.fl); end
    end
  endtask

  task automatic test_mode_change();
    exp_t e;
    sw_mode = 2'b10;
    push_steady(4'b1000, 2);
    push_flash(4'b0010, 0, FLASH_LEN + 3);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_cmp++; if (led_mode !== e.led) begin n_err++; $display("FAIL mode_change_led: got %b want %b", led_mode, e.led); end
      n_cmp++; if (led_stat !== e.stat) begin n_err++; $display("FAIL mode_change_stat: got %b want %b", led_stat, e.stat); end
      n_cmp++; if (flashing !== e.fl) begin n_err++; $display("FAIL mode_change_flashing: got %b want %b", flashing, e.fl); end
    end
  endtask

  task automatic test_restart();
    exp_t e;
    sw_mode = 2'b00;
    push_steady(4'b0010, 2);
    push_flash(4'b1000, 0, FLASH_LEN + 1);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_cmp++; if (led_mode !== e.led) begin n_err++; $display("FAIL restart_setup_led: got %b want %b", led_mode, e.led); end
      n_cmp++; if (flashing !== e.fl) begin n_err++; $display("FAIL restart_setup_flashing: got %b want %b", flashing, e.fl); end
    end
    sw_mode = 2'b10;
    push_steady(4'b1000, 2);
    push_flash(4'b0010, 0, 9);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_cmp++; if (led_mode !== e.led) begin n_err++; $display("FAIL restart_first_led: got %b want %b", led_mode, e.led); end
      n_cmp++; if (flashing !== e.fl) begin n_err++; $display("FAIL restart_first_flashing: got %b want %b", flashing, e.fl); end
    end
    sw_mode = 2'b11;
    push_flash(4'b0010, 10, 11);
    push_flash(4'b0001, 0, FLASH_LEN + 3);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_cmp++; if (led_mode !== e.led) begin n_err++; $display("FAIL restart_led: got %b want %b", led_mode, e.led); end
      n_cmp++; if (flashing !== e.fl) begin n_err++; $display("FAIL restart_flashing: got %b want %b", flashing, e.fl); end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    sw_mode = 2'b10;
    push_steady(4'b0001, 2);
    push_flash(4'b0010, 0, FLASH_LEN + 1);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      n_cmp++; if (led_mode !== e.led) begin n_err++; $display("FAIL glitch_setup_led: got %b want %b", led_mode, e.led); end
    end
    sw_mode = 2'b11;
    step();
    sw_mode = 2'b10;
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++; if ($countones(led_mode) > 1) begin n_err++; $display("FAIL glitch_onehot: got %b want at most one bit", led_mode); end
    end
    n_cmp++; if (led_mode !== 4'b0010) begin n_err++; $display("FAIL glitch_final_led: got %b want 0010", led_mode); end
    n_cmp++; if (flashing !== 1'b0) begin n_err++; $display("FAIL glitch_final_flashing: got %b want 0", flashing); end
  endtask

  task automatic test_reset_mid_flash();
    sw_mode = 2'b00;
    repeat (8) step();
    n_cmp++; if (flashing !== 1'b1) begin n_err++; $display("FAIL midflash_pre: got %b want 1", flashing); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (led_mode !== 4'b0000) begin n_err++; $display("FAIL midflash_async_led: got %b want 0000", led_mode); end
    n_cmp++; if (led_stat !== 1'b0) begin n_err++; $display("FAIL midflash_async_stat: got %b want 0", led_stat); end
    n_cmp++; if (flashing !== 1'b0) begin n_err++; $display("FAIL midflash_async_flashing: got %b want 0", flashing); end
    test_reset();
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    logic [3:0] duties[3];
    int         want[3];
    int         hi_stat, hi_led;
    duties[0] = 4'd4;  want[0] = 8;
    duties[1] = 4'd15; want[1] = 32;
    duties[2] = 4'd0;  want[2] = 0;
    for (int k = 0; k < 3; k++) begin
      duty = duties[k];
      repeat (3) step();
      hi_stat = 0; hi_led = 0;
      for (int i = 0; i < 32; i++) begin
        step();
        if (led_stat === 1'b1) hi_stat++;
        if (led_mode === 4'b1000) hi_led++;
      end
      n_cmp++; if (hi_stat != want[k]) begin n_err++; $display("FAIL pwm_stat duty=%0d: got %0d high want %0d", duties[k], hi_stat, want[k]); end
      n_cmp++; if (hi_led != want[k]) begin n_err++; $display("FAIL pwm_led duty=%0d: got %0d high want %0d", duties[k], hi_led, want[k]); end
    end
    duty = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_mode_change();
    test_restart();
    test_glitch();
    test_reset_mid_flash();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
